xosera_bus_sequencer: RTL and testbench
=======================================

// Module: xosera_bus_sequencer
// PURPOSE
//  Sequences CPU accesses into Xosera's 8-bit register bus and generates SETUP/STROBE/HOLD timing.
//  Each 16-bit access is split into two byte cycles: even/high byte (bytesel=0) first, then odd/low (bytesel=1).
//  Sits between the top-level address decode (0xA000 write window, 0xB000 read window) and xosera_main.
//  Asserts busy, which the CPU uses as hold, until the access completes.
// PARAMETERS
//  SETUP_CYC  1  cycles reg_num/bytesel/rd_nwr/data are stable before cs_n falls (>=1)
//  STROBE_CYC 2  cycles cs_n is held low per byte (>=1)
//  HOLD_CYC   1  cycles signals are held after cs_n rises (>=1)
//  CNT_W      4  phase counter width; must hold max(SETUP_CYC,STROBE_CYC,HOLD_CYC)-1
// PORTS
//  clk            in   1   system clock; all logic on posedge
//  reset_n        in   1   asynchronous, active-low reset
//  req_i          in   1   access request, sampled only in IDLE
//  wr_i           in   1   1=write, 0=read; captured with req_i
//  size16_i       in   1   1=two byte cycles (high then low); 0=low byte only
//  reg_num_i      in   4   Xosera register number; captured with req_i
//  wdata_i        in   16  write data; captured with req_i
//  busy_o         out  1   high from the cycle after acceptance through the DONE cycle
//  done_o         out  1   1-cycle pulse when the access completes
//  rdata_o        out  16  read data; valid from done_o, held until the next read completes
//  bus_cs_n_o     out  1   Xosera chip select, active low
//  bus_rd_nwr_o   out  1   Xosera 1=read, 0=write
//  bus_reg_num_o  out  4   Xosera register number
//  bus_bytesel_o  out  1   0=even/high byte, 1=odd/low byte
//  bus_data_o     out  8   byte to Xosera
//  bus_data_i     in   8   byte from Xosera
// BEHAVIOUR
//  Reset values (async on reset_n low):
//   - state=IDLE, busy_o=0, done_o=0, rdata_o=0
//   - bus_cs_n_o=1, bus_rd_nwr_o=1, bus_reg_num_o=0, bus_bytesel_o=0, bus_data_o=0
//  Reset mid-access: cs_n rises immediately and the access is abandoned; no done_o is issued.
//  All bus_* outputs are registered.
//  FSM states: IDLE -> SETUP -> STROBE -> HOLD -> (NEXT -> SETUP ...) -> DONE -> IDLE
//  IDLE:
//   - On req_i=1, capture wr/size16/reg_num/wdata.
//   - Set byte index: hi if size16_i, else lo.
//   - Go to SETUP.
//   - bus_rd_nwr_o idles at 1; bus_data_o idles at 0.
//  SETUP:
//   - Drive reg_num, bytesel=index, rd_nwr=~wr, data=wdata[15:8] (hi) or wdata[7:0] (lo).
//   - cs_n=1. Stay SETUP_CYC cycles.
//  STROBE:
//   - cs_n=0 for STROBE_CYC cycles; all other outputs unchanged.
//   - Read: sample bus_data_i on the last STROBE cycle into rdata byte[index].
//  HOLD:
//   - cs_n=1, other outputs unchanged, for HOLD_CYC cycles.
//   - Then: if index=hi, go to NEXT (index=lo, 0 cycles, directly to SETUP); else go to DONE.
//  DONE:
//   - done_o=1 for one cycle; busy_o still 1.
//   - Next cycle: IDLE, busy_o=0.
//  Latency: req cycle to done_o = 1 + nbytes*(SETUP_CYC+STROBE_CYC+HOLD_CYC) cycles.
//   - Defaults, size16: 9 cycles. Defaults, byte: 5 cycles.
//  req_i outside IDLE (including the DONE cycle) is ignored, not queued.
//  Back-to-back: req_i may be high in the cycle busy_o returns to 0 and is accepted then.
//  Read with size16=0: only rdata_o[7:0] updates; [15:8] keeps its old value.
//  Writes never modify rdata_o.
//  Phase counter reloads to N-1 on phase entry and decrements to 0; no wrap beyond a phase.
// TESTING
//  1. Write req, reg=3, wdata=0xBEEF, size16=1, defaults:
//     cs_n low 2 cycles with bytesel=0 data=0xBE, then 2 cycles bytesel=1 data=0xEF;
//     rd_nwr=0 throughout; done_o 9 cycles after req.
//  2. Read req, reg=5, size16=1, bench drives bus_data_i=0x12 in first strobe and 0x34 in second:
//     rdata_o=0x1234 at done_o.
//  3. Byte write, size16=0, wdata=0x00A5:
//     single cs_n pulse with bytesel=1 data=0xA5; done_o 5 cycles after req; busy_o high for 5 cycles.
//  4. Second req held high during a busy access:
//     ignored until IDLE; req in the first idle cycle is accepted the same cycle.
//  5. reset_n low during STROBE:
//     cs_n=1 asynchronously; all outputs at reset values; no done_o; next req after release runs normally.
//  6. SETUP_CYC=2, STROBE_CYC=3, HOLD_CYC=2, size16=1 write:
//     cs_n low exactly 3 cycles per byte; data stable 2 cycles before and after; done_o 15 cycles after req.

Source files
------------

// File: rtl/xosera_bus_sequencer_if.sv
// CPU-side request/response and Xosera 8-bit register bus signals for the bus sequencer.
interface xosera_bus_sequencer_if;
    logic        req;
    logic        wr;
    logic        size16;
    logic [3:0]  reg_num;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic [15:0] rdata;
    logic        bus_cs_n;
    logic        bus_rd_nwr;
    logic [3:0]  bus_reg_num;
    logic        bus_bytesel;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;

    modport slave (
        input  req, wr, size16, reg_num, wdata, bus_rdata,
        output busy, done, rdata, bus_cs_n, bus_rd_nwr, bus_reg_num, bus_bytesel, bus_wdata
    );

    modport master (
        output req, wr, size16, reg_num, wdata, bus_rdata,
        input  busy, done, rdata, bus_cs_n, bus_rd_nwr, bus_reg_num, bus_bytesel, bus_wdata
    );
endinterface

// File: rtl/xosera_bus_sequencer.sv
// Splits CPU accesses into one or two Xosera byte cycles with SETUP/STROBE/HOLD timing.
module xosera_bus_sequencer #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    xosera_bus_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [15:0]      rdata_q, rdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cs_n_q, cs_n_d;
    logic             rd_nwr_q, rd_nwr_d;
    logic [3:0]       reg_num_q, reg_num_d;
    logic             bytesel_q, bytesel_d;
    logic [7:0]       bdata_q, bdata_d;

    // Outputs are registered copies of the values for the state being entered;
    // bytesel_q doubles as the byte index (0=high, 1=low) and rd_nwr_q as ~wr.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cs_n_d    = cs_n_q;
        rd_nwr_d  = rd_nwr_q;
        reg_num_d = reg_num_q;
        bytesel_d = bytesel_q;
        bdata_d   = bdata_q;

        unique case (state)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.req) begin
                    state_d   = SETUP;
                    cnt_d     = SETUP_LD;
                    wdata_d   = bus.wdata;
                    busy_d    = 1'b1;
                    rd_nwr_d  = ~bus.wr;
                    reg_num_d = bus.reg_num;
                    bytesel_d = ~bus.size16;
                    bdata_d   = bus.size16 ? bus.wdata[15:8] : bus.wdata[7:0];
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LD;
                    cs_n_d  = 1'b0;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                    cs_n_d  = 1'b1;
                    if (rd_nwr_q) begin
                        if (bytesel_q) rdata_d[7:0]  = bus.bus_rdata;
                        else           rdata_d[15:8] = bus.bus_rdata;
                    end
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    if (!bytesel_q) begin
                        state_d   = SETUP;
                        cnt_d     = SETUP_LD;
                        bytesel_d = 1'b1;
                        bdata_d   = wdata_q[7:0];
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            DONE: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                rd_nwr_d = 1'b1;
                bdata_d  = 8'h00;
            end
            default: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                cs_n_d   = 1'b1;
                rd_nwr_d = 1'b1;
                bdata_d  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            rd_nwr_q  <= 1'b1;
            reg_num_q <= '0;
            bytesel_q <= 1'b0;
            bdata_q   <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cs_n_q    <= cs_n_d;
            rd_nwr_q  <= rd_nwr_d;
            reg_num_q <= reg_num_d;
            bytesel_q <= bytesel_d;
            bdata_q   <= bdata_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.rdata       = rdata_q;
    assign bus.bus_cs_n    = cs_n_q;
    assign bus.bus_rd_nwr  = rd_nwr_q;
    assign bus.bus_reg_num = reg_num_q;
    assign bus.bus_bytesel = bytesel_q;
    assign bus.bus_wdata   = bdata_q;

endmodule

// File: tb/tb_xosera_bus_sequencer.sv
// Bench for xosera_bus_sequencer: default-timing and slow-timing instances checked cycle by cycle.
module tb_xosera_bus_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_f, req_s, wr, size16;
    logic [3:0]  reg_num;
    logic [15:0] wdata;
    logic [7:0]  rd_hi, rd_lo;
    logic [15:0] mdl_f, mdl_s;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    xosera_bus_sequencer_if fi ();
    xosera_bus_sequencer_if si ();

    assign fi.req = req_f;   assign si.req = req_s;
    assign fi.wr = wr;       assign si.wr = wr;
    assign fi.size16 = size16; assign si.size16 = size16;
    assign fi.reg_num = reg_num; assign si.reg_num = reg_num;
    assign fi.wdata = wdata; assign si.wdata = wdata;

    // Xosera stand-in: returns the addressed byte only while selected
    assign fi.bus_rdata = !fi.bus_cs_n ? (fi.bus_bytesel ? rd_lo : rd_hi) : 8'h5A;
    assign si.bus_rdata = !si.bus_cs_n ? (si.bus_bytesel ? rd_lo : rd_hi) : 8'h5A;

    xosera_bus_sequencer dut_f (.clk(clk), .reset_n(reset_n), .bus(fi.slave));
    xosera_bus_sequencer #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2), .CNT_W(4))
        dut_s (.clk(clk), .reset_n(reset_n), .bus(si.slave));

    // {busy, done, cs_n, rd_nwr, reg_num, bytesel, data}
    function automatic logic [16:0] obs(input bit slow);
        if (slow) return {si.busy, si.done, si.bus_cs_n, si.bus_rd_nwr, si.bus_reg_num, si.bus_bytesel, si.bus_wdata};
        return {fi.busy, fi.done, fi.bus_cs_n, fi.bus_rd_nwr, fi.bus_reg_num, fi.bus_bytesel, fi.bus_wdata};
    endfunction

    function automatic logic [15:0] rdat(input bit slow);
        return slow ? si.rdata : fi.rdata;
    endfunction

    localparam logic [16:0] RESET_OBS = {1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 8'h00};

    task automatic wait_idle(input bit slow);
        int i = 0;
        @(negedge clk);
        while (obs(slow)[16] && i < 100) begin
            @(negedge clk);
            i++;
        end
        vectors++;
        if (i >= 100) begin
            miscompares++;
            $display("FAIL wait_idle slow=%0d: busy still %b after %0d cycles, required 0", slow, obs(slow)[16], i);
        end
    endtask

    // One access; every cycle from acceptance to the following idle cycle is compared against
    // a trace computed from the phase lengths. keep leaves req high; chained starts without waiting.
    task automatic do_access(input bit slow, input bit w, input bit s16, input logic [3:0] rn,
                             input logic [15:0] wd, input logic [7:0] hi, input logic [7:0] lo,
                             input bit chained, input bit keep);
        int sc, tc, hc, per, nb, n, b, ph;
        logic bs;
        logic [16:0] exp_o, got_o;
        logic [15:0] exp_r;
        sc = slow ? 2 : 1;
        tc = slow ? 3 : 2;
        hc = slow ? 2 : 1;
        per = sc + tc + hc;
        nb = s16 ? 2 : 1;
        n = 1 + nb * per;
        if (!chained) wait_idle(slow);
        wr = w; size16 = s16; reg_num = rn; wdata = wd; rd_hi = hi; rd_lo = lo;
        if (slow) req_s = 1'b1; else req_f = 1'b1;
        exp_r = slow ? mdl_s : mdl_f;
        if (!w) begin
            if (s16) exp_r = {hi, lo};
            else     exp_r[7:0] = lo;
        end
        if (slow) mdl_s = exp_r; else mdl_f = exp_r;
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            if (k == 1 && !keep) begin
                req_f = 1'b0;
                req_s = 1'b0;
            end
            if (k < n) begin
                b  = (k - 1) / per;
                ph = (k - 1) % per;
                bs = s16 ? (b == 1) : 1'b1;
                exp_o = {1'b1, 1'b0, !(ph >= sc && ph < sc + tc), !w, rn, bs, bs ? wd[7:0] : wd[15:8]};
            end else if (k == n) begin
                exp_o = {1'b1, 1'b1, 1'b1, !w, rn, 1'b1, wd[7:0]};
            end else begin
                exp_o = {1'b0, 1'b0, 1'b1, 1'b1, rn, 1'b1, 8'h00};
            end
            got_o = obs(slow);
            vectors++;
            if (got_o !== exp_o) begin
                miscompares++;
                $display("FAIL trace slow=%0d wr=%0d s16=%0d cyc=%0d: got %h required %h (busy,done,cs_n,rd_nwr,reg,bsel,data)",
                         slow, w, s16, k, got_o, exp_o);
            end
            if (k >= n) begin
                vectors++;
                if (rdat(slow) !== exp_r) begin
                    miscompares++;
                    $display("FAIL rdata slow=%0d cyc=%0d: got %h required %h", slow, k, rdat(slow), exp_r);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_f = 0; req_s = 0; wr = 0; size16 = 0; reg_num = 0; wdata = 0; rd_hi = 0; rd_lo = 0;
        mdl_f = 0; mdl_s = 0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            vectors++;
            if (obs(s[0]) !== RESET_OBS || rdat(s[0]) !== 16'h0) begin
                miscompares++;
                $display("FAIL reset_state slow=%0d: got %h/%h required %h/0000", s, obs(s[0]), rdat(s[0]), RESET_OBS);
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        do_access(0, 1, 1, 4'd3, 16'hBEEF, 8'h00, 8'h00, 0, 0);
        do_access(0, 0, 1, 4'd5, 16'h0000, 8'h12, 8'h34, 0, 0);
        do_access(0, 1, 0, 4'd7, 16'h00A5, 8'h00, 8'h00, 0, 0);
        do_access(0, 0, 0, 4'd9, 16'hFFFF, 8'hEE, 8'h56, 0, 0);
    endtask

    task automatic test_back_to_back();
        do_access(0, 1, 1, 4'd1, 16'h1357, 8'h00, 8'h00, 0, 1);
        do_access(0, 0, 1, 4'd2, 16'h2468, 8'hAB, 8'hCD, 1, 1);
        do_access(0, 1, 0, 4'd4, 16'h00C3, 8'h00, 8'h00, 1, 0);
    endtask

    task automatic test_reset_mid_access();
        wait_idle(0);
        wr = 0; size16 = 1; reg_num = 4'd6; wdata = 16'h0; rd_hi = 8'h77; rd_lo = 8'h88;
        req_f = 1'b1;
        @(negedge clk);
        req_f = 1'b0;
        @(negedge clk);
        vectors++;
        if (fi.bus_cs_n !== 1'b0) begin
            miscompares++;
            $display("FAIL strobe_before_reset: cs_n got %b required 0", fi.bus_cs_n);
        end
        #2 reset_n = 1'b0;
        #1;
        mdl_f = 0; mdl_s = 0;
        vectors++;
        if (obs(0) !== RESET_OBS || rdat(0) !== 16'h0) begin
            miscompares++;
            $display("FAIL async_reset: got %h/%h required %h/0000", obs(0), rdat(0), RESET_OBS);
        end
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (obs(0) !== RESET_OBS) begin
                miscompares++;
                $display("FAIL held_reset: got %h required %h", obs(0), RESET_OBS);
            end
        end
        reset_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            vectors++;
            if (obs(0) !== RESET_OBS) begin
                miscompares++;
                $display("FAIL no_done_after_reset: got %h required %h", obs(0), RESET_OBS);
            end
        end
        do_access(0, 0, 1, 4'd6, 16'h0, 8'h77, 8'h88, 0, 0);
    endtask

    task automatic test_slow_timing();
        do_access(1, 1, 1, 4'd3, 16'hBEEF, 8'h00, 8'h00, 0, 0);
        do_access(1, 0, 1, 4'd8, 16'h0, 8'h9A, 8'hBC, 0, 0);
        for (int i = 0; i < 5; i++)
            do_access(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                      16'($urandom), 8'($urandom), 8'($urandom), 0, 0);
    endtask

    task automatic test_random();
        bit kp = 1'b0;
        bit nk;
        for (int i = 0; i < 30; i++) begin
            nk = (i < 29) && ($urandom_range(0, 3) == 0);
            do_access(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                      16'($urandom), 8'($urandom), 8'($urandom), kp, nk);
            kp = nk;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_access();
        test_slow_timing();
        test_random();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
